// File: rtl/fp_cmp_axis_issuer.sv
// fp_cmp_axis_issuer
//
// Issues operand pairs to an AXI-Stream floating-point compare core and collects its
// condition codes. Each result is turned into a boolean response according to the opcode
// of the matching request. Responses come back in request order.
//
// Ports:
//   aclk, areset        clock; synchronous active-high reset
//   req_*               request in (valid/ready, operands a/b, 3-bit opcode)
//   m_axis_a_*          operand A stream to the core
//   m_axis_b_*          operand B stream to the core
//   s_axis_result_*     condition code from the core, tdata[3:0] = {un, gt, lt, eq}
//   resp_*              response out (valid/ready, {31'b0, flag}, unordered)
//   busy                work outstanding, an operand pending, or a response pending
//   timeout_err         sticky watchdog flag (0 unless FPCMP_TIMEOUT_EN is defined)
//
// Build option: define FPCMP_TIMEOUT_EN to enable the watchdog.

module fp_cmp_axis_issuer #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 64
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [2:0]  req_op,
    output logic        m_axis_a_tvalid,
    input  logic        m_axis_a_tready,
    output logic [31:0] m_axis_a_tdata,
    output logic        m_axis_b_tvalid,
    input  logic        m_axis_b_tready,
    output logic [31:0] m_axis_b_tdata,
    input  logic        s_axis_result_tvalid,
    output logic        s_axis_result_tready,
    input  logic [7:0]  s_axis_result_tdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic        resp_unordered,
    output logic        busy,
    output logic        timeout_err
);

    localparam int unsigned AW = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_SEND = 1'b1;

    localparam logic [2:0] OP_EQ = 3'd0;
    localparam logic [2:0] OP_NE = 3'd1;
    localparam logic [2:0] OP_LT = 3'd2;
    localparam logic [2:0] OP_LE = 3'd3;
    localparam logic [2:0] OP_GT = 3'd4;
    localparam logic [2:0] OP_GE = 3'd5;

    logic          a_state_q, b_state_q;
    logic [CW-1:0] outstanding_q;
    logic [2:0]    op_fifo_q [MAX_OUTSTANDING];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [2:0]    head_op;
    logic          req_hs, res_hs, resp_hs, a_hs, b_hs;
    logic          cc_eq, cc_lt, cc_gt, cc_un;
    logic          flag;
    logic          unused_tdata;

    assign unused_tdata = ^s_axis_result_tdata[7:4];

    assign cc_eq = s_axis_result_tdata[0];
    assign cc_lt = s_axis_result_tdata[1];
    assign cc_gt = s_axis_result_tdata[2];
    assign cc_un = s_axis_result_tdata[3];

    assign m_axis_a_tvalid = (a_state_q == ST_SEND);
    assign m_axis_b_tvalid = (b_state_q == ST_SEND);
    assign a_hs = m_axis_a_tvalid && m_axis_a_tready;
    assign b_hs = m_axis_b_tvalid && m_axis_b_tready;

    // The opcode FIFO occupancy always equals the outstanding count, so the counter
    // doubles as the FIFO level.
    assign req_ready = !areset && (a_state_q == ST_IDLE) && (b_state_q == ST_IDLE)
                       && (outstanding_q < MAX_CNT);
    assign s_axis_result_tready = !areset && (outstanding_q != '0)
                                  && (!resp_valid || resp_ready);

    assign req_hs  = req_valid && req_ready;
    assign res_hs  = s_axis_result_tvalid && s_axis_result_tready;
    assign resp_hs = resp_valid && resp_ready;
    assign head_op = op_fifo_q[rd_ptr_q];

    assign busy = (outstanding_q != '0) || m_axis_a_tvalid || m_axis_b_tvalid || resp_valid;

    // NaN makes every relation false, so only NE reports true.
    always_comb begin
        flag = 1'b0;
        if (cc_un) begin
            flag = (head_op == OP_NE);
        end else begin
            case (head_op)
                OP_EQ:   flag = cc_eq;
                OP_NE:   flag = !cc_eq;
                OP_LT:   flag = cc_lt;
                OP_LE:   flag = cc_lt || cc_eq;
                OP_GT:   flag = cc_gt;
                OP_GE:   flag = cc_gt || cc_eq;
                default: flag = 1'b0;
            endcase
        end
    end

    // Opcode storage needs no reset; only the pointers define validity.
    always_ff @(posedge aclk) begin
        if (req_hs) begin
            op_fifo_q[wr_ptr_q] <= req_op;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            a_state_q      <= ST_IDLE;
            b_state_q      <= ST_IDLE;
            m_axis_a_tdata <= '0;
            m_axis_b_tdata <= '0;
            outstanding_q  <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            resp_valid     <= 1'b0;
            resp_result    <= '0;
            resp_unordered <= 1'b0;
        end else begin
            // Accept only happens with both channels idle, so no conflict with a_hs/b_hs.
            if (req_hs) begin
                a_state_q      <= ST_SEND;
                b_state_q      <= ST_SEND;
                m_axis_a_tdata <= req_a;
                m_axis_b_tdata <= req_b;
                wr_ptr_q       <= wr_ptr_q + AW'(1);
            end else begin
                if (a_hs) a_state_q <= ST_IDLE;
                if (b_hs) b_state_q <= ST_IDLE;
            end

            case ({req_hs, res_hs})
                2'b10:   outstanding_q <= outstanding_q + CW'(1);
                2'b01:   outstanding_q <= outstanding_q - CW'(1);
                default: outstanding_q <= outstanding_q;
            endcase

            if (res_hs) begin
                rd_ptr_q       <= rd_ptr_q + AW'(1);
                resp_valid     <= 1'b1;
                resp_result    <= {31'b0, flag};
                resp_unordered <= cc_un;
            end else if (resp_hs) begin
                resp_valid <= 1'b0;
            end
        end
    end

`ifdef FPCMP_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt_q;
    logic          timeout_err_q;

    // Counter saturates at the limit; the error flag is sticky until reset.
    always_ff @(posedge aclk) begin
        if (areset) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else if (res_hs) begin
            tmo_cnt_q <= '0;
        end else if ((outstanding_q != '0) && (tmo_cnt_q != TW'(TIMEOUT_CYCLES))) begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
            if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_fp_cmp_axis_issuer.sv
// Self-checking bench for fp_cmp_axis_issuer: directed compare cases, backpressure,
// mid-flight reset, randomized traffic against a reference model, and the watchdog.
module tb_fp_cmp_axis_issuer;

    localparam int MAX = 4;

    logic        aclk = 1'b0;
    logic        areset;
    logic        req_valid, req_ready;
    logic [31:0] req_a, req_b;
    logic [2:0]  req_op;
    logic        m_axis_a_tvalid, m_axis_a_tready;
    logic [31:0] m_axis_a_tdata;
    logic        m_axis_b_tvalid, m_axis_b_tready;
    logic [31:0] m_axis_b_tdata;
    logic        s_axis_result_tvalid, s_axis_result_tready;
    logic [7:0]  s_axis_result_tdata;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_result;
    logic        resp_unordered, busy, timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    fp_cmp_axis_issuer #(.MAX_OUTSTANDING(MAX), .TIMEOUT_CYCLES(64)) dut (
        .aclk                 (aclk),
        .areset               (areset),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_a                (req_a),
        .req_b                (req_b),
        .req_op               (req_op),
        .m_axis_a_tvalid      (m_axis_a_tvalid),
        .m_axis_a_tready      (m_axis_a_tready),
        .m_axis_a_tdata       (m_axis_a_tdata),
        .m_axis_b_tvalid      (m_axis_b_tvalid),
        .m_axis_b_tready      (m_axis_b_tready),
        .m_axis_b_tdata       (m_axis_b_tdata),
        .s_axis_result_tvalid (s_axis_result_tvalid),
        .s_axis_result_tready (s_axis_result_tready),
        .s_axis_result_tdata  (s_axis_result_tdata),
        .resp_valid           (resp_valid),
        .resp_ready           (resp_ready),
        .resp_result          (resp_result),
        .resp_unordered       (resp_unordered),
        .busy                 (busy),
        .timeout_err          (timeout_err)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- reference model ----------------
    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hff) && (x[22:0] != 23'd0);
    endfunction

    // Maps an IEEE single to an integer with the same ordering; +0 and -0 both map to 0.
    function automatic longint ord(input logic [31:0] x);
        longint m;
        m = longint'(x[30:0]);
        return x[31] ? -m : m;
    endfunction

    function automatic bit ref_flag(input logic [2:0] op, input logic [31:0] a, b);
        longint va, vb;
        if (is_nan(a) || is_nan(b)) return (op == 3'd1);
        va = ord(a);
        vb = ord(b);
        case (op)
            3'd0:    return va == vb;
            3'd1:    return va != vb;
            3'd2:    return va <  vb;
            3'd3:    return va <= vb;
            3'd4:    return va >  vb;
            3'd5:    return va >= vb;
            default: return 1'b0;
        endcase
    endfunction

    // Behaviour of the compare core: {un, gt, lt, eq}.
    function automatic logic [3:0] core_cc(input logic [31:0] a, b);
        if (is_nan(a) || is_nan(b)) return 4'b1000;
        return {1'b0, ord(a) > ord(b), ord(a) < ord(b), ord(a) == ord(b)};
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h3fc00000;
            1:       return 32'h40200000;
            2:       return 32'h7fc00000;
            3:       return 32'h80000000;
            4:       return 32'h00000000;
            5:       return 32'hff800000;
            6:       return 32'hbf800000;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic idle_inputs();
        req_valid = 0; req_a = 0; req_b = 0; req_op = 0;
        m_axis_a_tready = 0; m_axis_b_tready = 0;
        s_axis_result_tvalid = 0; s_axis_result_tdata = 0;
        resp_ready = 0;
    endtask

    task automatic apply_reset();
        @(negedge aclk);
        areset = 1;
        idle_inputs();
        repeat (2) @(negedge aclk);
        areset = 0;
    endtask

    task automatic send_req(input logic [2:0] op, input logic [31:0] a, b, output bit ok);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (req_ready) begin
                ok = 1;
                break;
            end
        end
        if (ok) begin
            req_valid = 1; req_op = op; req_a = a; req_b = b;
            @(negedge aclk);
            req_valid = 0;
        end
    endtask

    // Returns at the negedge after the result handshake.
    task automatic send_result(input logic [3:0] cc, output bit ok);
        ok = 0;
        @(negedge aclk);
        s_axis_result_tvalid = 1;
        s_axis_result_tdata  = {4'h5, cc};
        for (int i = 0; i < 50; i++) begin
            #1;
            if (s_axis_result_tready) begin
                ok = 1;
                break;
            end
            @(negedge aclk);
        end
        @(negedge aclk);
        s_axis_result_tvalid = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge aclk);
        areset = 1;
        idle_inputs();
        req_valid = 1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready);
        end
        repeat (2) @(negedge aclk);
        checks++;
        if ({m_axis_a_tvalid, m_axis_b_tvalid, resp_valid, s_axis_result_tready,
             timeout_err, resp_unordered, busy} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0", {m_axis_a_tvalid, m_axis_b_tvalid,
                     resp_valid, s_axis_result_tready, timeout_err, resp_unordered, busy});
        end
        checks++;
        if ({m_axis_a_tdata, m_axis_b_tdata, resp_result} !== 96'b0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h want 0", m_axis_a_tdata, m_axis_b_tdata,
                     resp_result);
        end
        req_valid = 0;
        areset = 0;
        @(negedge aclk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL post_reset_req_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  op1 [4] = '{3'd1, 3'd1, 3'd4, 3'd0};
        logic [2:0]  op2 [4] = '{3'd2, 3'd0, 3'd3, 3'd1};
        logic [31:0] va  [4] = '{32'h3fc00000, 32'h3fc00000, 32'h40200000, 32'h7fc00000};
        logic [31:0] vb  [4] = '{32'h40200000, 32'h3fc00000, 32'h3fc00000, 32'h3f800000};
        logic [3:0]  cc  [4] = '{4'h2, 4'h1, 4'h4, 4'h8};
        logic [31:0] e1  [4] = '{32'h1, 32'h0, 32'h1, 32'h0};
        logic [31:0] e2  [4] = '{32'h1, 32'h1, 32'h0, 32'h1};
        logic        eun [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        bit ok;
        m_axis_a_tready = 1; m_axis_b_tready = 1; resp_ready = 1;
        for (int k = 0; k < 4; k++) begin
            send_req(op1[k], va[k], vb[k], ok);
            checks++;
            if (!ok || m_axis_a_tvalid !== 1'b1 || m_axis_b_tvalid !== 1'b1 ||
                m_axis_a_tdata !== va[k] || m_axis_b_tdata !== vb[k]) begin
                errors++;
                $display("FAIL dir%0d_issue: ok=%b tvalid=%b%b a=%h b=%h want 11 %h %h", k, ok,
                         m_axis_a_tvalid, m_axis_b_tvalid, m_axis_a_tdata, m_axis_b_tdata,
                         va[k], vb[k]);
            end
            send_req(op2[k], va[k], vb[k], ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL dir%0d_issue2: got 0 want 1", k); end
            send_result(cc[k], ok);
            checks++;
            if (!ok || resp_valid !== 1'b1 || resp_result !== e1[k] ||
                resp_unordered !== eun[k]) begin
                errors++;
                $display("FAIL dir%0d_resp1: v=%b r=%h u=%b want 1 %h %b", k, resp_valid,
                         resp_result, resp_unordered, e1[k], eun[k]);
            end
            send_result(cc[k], ok);
            checks++;
            if (!ok || resp_valid !== 1'b1 || resp_result !== e2[k] ||
                resp_unordered !== eun[k]) begin
                errors++;
                $display("FAIL dir%0d_resp2: v=%b r=%h u=%b want 1 %h %b", k, resp_valid,
                         resp_result, resp_unordered, e2[k], eun[k]);
            end
            @(negedge aclk);
            checks++;
            if (resp_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_idle: resp_valid=%b busy=%b want 0 0", k, resp_valid, busy);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        m_axis_a_tready = 0; m_axis_b_tready = 1; resp_ready = 1;
        send_req(3'd0, 32'h12345678, 32'h3f800000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_issue: got 0 want 1"); end
        repeat (5) begin
            @(negedge aclk);
            checks++;
            if (m_axis_a_tvalid !== 1'b1 || m_axis_a_tdata !== 32'h12345678 ||
                req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: tvalid=%b tdata=%h req_ready=%b want 1 12345678 0",
                         m_axis_a_tvalid, m_axis_a_tdata, req_ready);
            end
        end
        checks++;
        if (m_axis_b_tvalid !== 1'b0) begin
            errors++; $display("FAIL bp_b_done: got %b want 0", m_axis_b_tvalid);
        end
        m_axis_a_tready = 1;
        @(negedge aclk);
        checks++;
        if (m_axis_a_tvalid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: tvalid=%b req_ready=%b want 0 1", m_axis_a_tvalid,
                     req_ready);
        end
        for (int i = 0; i < 3; i++) begin
            send_req(3'd0, 32'h3f800000, 32'h3f800000, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL bp_fill%0d: got 0 want 1", i); end
        end
        @(negedge aclk);
        req_valid = 1; req_op = 3'd0;
        repeat (5) begin
            @(negedge aclk);
            checks++;
            if (req_ready !== 1'b0 || m_axis_a_tvalid !== 1'b0) begin
                errors++;
                $display("FAIL bp_full_stall: req_ready=%b tvalid=%b want 0 0", req_ready,
                         m_axis_a_tvalid);
            end
        end
        req_valid = 0;
        resp_ready = 0;
        send_result(4'h1, ok);
        checks++;
        if (!ok || resp_valid !== 1'b1 || resp_result !== 32'h1) begin
            errors++;
            $display("FAIL bp_first_resp: ok=%b v=%b r=%h want 1 1 1", ok, resp_valid,
                     resp_result);
        end
        s_axis_result_tvalid = 1; s_axis_result_tdata = 8'h01;
        repeat (3) begin
            #1;
            checks++;
            if (s_axis_result_tready !== 1'b0 || resp_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_resp_stall: tready=%b resp_valid=%b want 0 1",
                         s_axis_result_tready, resp_valid);
            end
            @(negedge aclk);
        end
        s_axis_result_tvalid = 0;
        resp_ready = 1;
        for (int i = 0; i < 3; i++) begin
            send_result(4'h1, ok);
            checks++;
            if (!ok || resp_valid !== 1'b1 || resp_result !== 32'h1) begin
                errors++;
                $display("FAIL bp_drain%0d: ok=%b v=%b r=%h want 1 1 1", i, ok, resp_valid,
                         resp_result);
            end
        end
        @(negedge aclk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_midflight();
        bit ok;
        m_axis_a_tready = 0; m_axis_b_tready = 0; resp_ready = 1;
        send_req(3'd2, 32'h3fc00000, 32'h40200000, ok);
        apply_reset();
        #1;
        checks++;
        if ({busy, m_axis_a_tvalid, m_axis_b_tvalid, s_axis_result_tready} !== 4'b0 ||
            req_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset: busy/tv/tv/rtready=%b req_ready=%b want 0000 1",
                     {busy, m_axis_a_tvalid, m_axis_b_tvalid, s_axis_result_tready}, req_ready);
        end
    endtask

    task automatic test_random(input int n);
        logic [2:0]  rq_op [$];
        logic [31:0] rq_a [$], rq_b [$], a_exp [$], b_exp [$], core_a [$], core_b [$];
        logic [3:0]  core_q [$];
        logic [31:0] resp_exp [$];
        logic        un_exp [$];
        logic [31:0] a_held = 0, b_held = 0;
        bit a_hold = 0, b_hold = 0, done = 0;
        int cnt = 0, cyc = 0;
        while (!done) begin
            @(negedge aclk);
            if (cyc < n) begin
                req_valid = ($urandom_range(0, 1) == 1);
                req_a = pick_operand(); req_b = pick_operand();
                req_op = 3'($urandom_range(0, 7));
                m_axis_a_tready = ($urandom_range(0, 3) != 0);
                m_axis_b_tready = ($urandom_range(0, 3) != 0);
                resp_ready = ($urandom_range(0, 3) != 0);
            end else begin
                req_valid = 0; m_axis_a_tready = 1; m_axis_b_tready = 1; resp_ready = 1;
            end
            if (core_q.size() > 0 && (cyc >= n || $urandom_range(0, 2) != 0)) begin
                s_axis_result_tvalid = 1;
                s_axis_result_tdata  = {4'($urandom_range(0, 15)), core_q[0]};
            end else begin
                s_axis_result_tvalid = ($urandom_range(0, 7) == 0) && (cnt == 0);
                s_axis_result_tdata  = 8'($urandom_range(0, 255));
            end
            #1;
            if (a_hold) begin
                checks++;
                if (m_axis_a_tvalid !== 1'b1 || m_axis_a_tdata !== a_held) begin
                    errors++;
                    $display("FAIL rnd_a_stable: v=%b d=%h want 1 %h", m_axis_a_tvalid,
                             m_axis_a_tdata, a_held);
                end
            end
            if (b_hold) begin
                checks++;
                if (m_axis_b_tvalid !== 1'b1 || m_axis_b_tdata !== b_held) begin
                    errors++;
                    $display("FAIL rnd_b_stable: v=%b d=%h want 1 %h", m_axis_b_tvalid,
                             m_axis_b_tdata, b_held);
                end
            end
            checks++;
            if (resp_valid !== (resp_exp.size() != 0)) begin
                errors++;
                $display("FAIL rnd_resp_valid: got %b want %b", resp_valid, resp_exp.size() != 0);
            end else if (resp_valid) begin
                checks++;
                if (resp_result !== resp_exp[0] || resp_unordered !== un_exp[0]) begin
                    errors++;
                    $display("FAIL rnd_resp_data: r=%h u=%b want %h %b", resp_result,
                             resp_unordered, resp_exp[0], un_exp[0]);
                end
                if (resp_ready) begin
                    void'(resp_exp.pop_front());
                    void'(un_exp.pop_front());
                end
            end
            if (cnt == 0 || cnt == MAX) begin
                checks++;
                if ((cnt == 0 && s_axis_result_tready !== 1'b0) ||
                    (cnt == MAX && req_ready !== 1'b0)) begin
                    errors++;
                    $display("FAIL rnd_limits: cnt=%0d rtready=%b req_ready=%b", cnt,
                             s_axis_result_tready, req_ready);
                end
            end
            if (s_axis_result_tvalid && s_axis_result_tready && cnt > 0) begin
                void'(core_q.pop_front());
                cnt--;
                resp_exp.push_back({31'b0, ref_flag(rq_op[0], rq_a[0], rq_b[0])});
                un_exp.push_back(is_nan(rq_a[0]) || is_nan(rq_b[0]));
                void'(rq_op.pop_front()); void'(rq_a.pop_front()); void'(rq_b.pop_front());
            end
            if (req_valid && req_ready) begin
                rq_op.push_back(req_op); rq_a.push_back(req_a); rq_b.push_back(req_b);
                a_exp.push_back(req_a); b_exp.push_back(req_b);
                cnt++;
            end
            if (m_axis_a_tvalid && m_axis_a_tready) begin
                checks++;
                if (a_exp.size() == 0 || m_axis_a_tdata !== a_exp[0]) begin
                    errors++;
                    $display("FAIL rnd_a_data: got %h want %h", m_axis_a_tdata,
                             a_exp.size() ? a_exp[0] : 32'hx);
                end
                if (a_exp.size() != 0) core_a.push_back(a_exp.pop_front());
            end
            if (m_axis_b_tvalid && m_axis_b_tready) begin
                checks++;
                if (b_exp.size() == 0 || m_axis_b_tdata !== b_exp[0]) begin
                    errors++;
                    $display("FAIL rnd_b_data: got %h want %h", m_axis_b_tdata,
                             b_exp.size() ? b_exp[0] : 32'hx);
                end
                if (b_exp.size() != 0) core_b.push_back(b_exp.pop_front());
            end
            a_hold = m_axis_a_tvalid && !m_axis_a_tready; a_held = m_axis_a_tdata;
            b_hold = m_axis_b_tvalid && !m_axis_b_tready; b_held = m_axis_b_tdata;
            while (core_a.size() > 0 && core_b.size() > 0)
                core_q.push_back(core_cc(core_a.pop_front(), core_b.pop_front()));
            cyc++;
            if (cyc >= n && cnt == 0 && a_exp.size() == 0 && b_exp.size() == 0 &&
                resp_exp.size() == 0)
                done = 1;
            if (!done && cyc >= n + 300) begin
                errors++;
                $display("FAIL rnd_drain: outstanding %0d want 0", cnt);
                done = 1;
            end
        end
        @(negedge aclk);
        idle_inputs();
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rnd_end_idle: busy=%b resp_valid=%b want 0 0", busy, resp_valid);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        bit exp_late;
`ifdef FPCMP_TIMEOUT_EN
        exp_late = 1'b1;
`else
        exp_late = 1'b0;
`endif
        apply_reset();
        m_axis_a_tready = 1; m_axis_b_tready = 1; resp_ready = 1;
        send_req(3'd0, 32'h3f800000, 32'h3f800000, ok);
        repeat (62) @(negedge aclk);
        checks++;
        if (!ok || timeout_err !== 1'b0) begin
            errors++; $display("FAIL tmo_early: ok=%b err=%b want 1 0", ok, timeout_err);
        end
        repeat (4) @(negedge aclk);
        checks++;
        if (timeout_err !== exp_late) begin
            errors++; $display("FAIL tmo_rise: got %b want %b", timeout_err, exp_late);
        end
        repeat (20) @(negedge aclk);
        checks++;
        if (timeout_err !== exp_late) begin
            errors++; $display("FAIL tmo_sticky: got %b want %b", timeout_err, exp_late);
        end
        apply_reset();
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++; $display("FAIL tmo_clear: got %b want 0", timeout_err);
        end
    endtask

    initial begin
        areset = 1;
        idle_inputs();
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midflight();
        test_random(1500);
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_cmp_axis_issuer.md
Name: fp_cmp_axis_issuer

Overview:
- Initiator and collector for the AXI-Stream floating-point compare core used by the compare wrappers (equal, not-equal, less-than, ...).
- Accepts operand pairs plus a compare opcode and drives them onto the core's A and B operand channels.
- Receives the core's 4-bit condition code, pairs it with the stored opcode and returns a 32-bit boolean result word.
- Replaces the per-op wrappers' free-running operand drive with a proper valid/ready handshake and tracks outstanding requests.

Parameters:
- MAX_OUTSTANDING, 4: maximum requests in flight inside the compare core; also the depth of the opcode FIFO. Power of two, 2 to 16.
- TIMEOUT_CYCLES, 64: watchdog limit in cycles. Used only with the optional feature.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  synchronous, active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted this cycle when req_valid is also high.
- req_a  in  32  IEEE-754 single-precision operand a.
- req_b  in  32  IEEE-754 single-precision operand b.
- req_op  in  3  opcode: 0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE, 6/7 reserved.
- m_axis_a_tvalid  out  1  operand A channel valid.
- m_axis_a_tready  in  1  operand A channel ready.
- m_axis_a_tdata  out  32  operand A data.
- m_axis_b_tvalid  out  1  operand B channel valid.
- m_axis_b_tready  in  1  operand B channel ready.
- m_axis_b_tdata  out  32  operand B data.
- s_axis_result_tvalid  in  1  condition-code result valid from the core.
- s_axis_result_tready  out  1  condition-code result ready.
- s_axis_result_tdata  in  8  [3:0] = {unordered, gt, lt, eq}; [7:4] ignored.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response ready.
- resp_result  out  32  {31'b0, flag}.
- resp_unordered  out  1  the compared pair contained a NaN.
- busy  out  1  high when outstanding != 0, any tvalid is high, or resp_valid is high.
- timeout_err  out  1  sticky watchdog error; see Optional Feature.

Behaviour:
- Reset (areset high at a clock edge), outputs:
  - all tvalid, resp_valid, req_ready, s_axis_result_tready and timeout_err = 0.
  - tdata, resp_result and resp_unordered = 0.
- Reset, internal state: outstanding counter = 0; opcode FIFO empty.
- Reset mid-operation discards all in-flight work. The compare core must be reset in the same cycle.
- Each operand channel has its own two-state FSM:
  - IDLE -> SEND on request accept.
  - SEND -> IDLE on that channel's tvalid && tready.
  - The A and B channels complete independently, in either order or in the same cycle.
- req_ready = both channel FSMs IDLE && outstanding < MAX_OUTSTANDING. It is low during reset.
- On accept (req_valid && req_ready):
  - req_a and req_b are registered into the tdata outputs.
  - Both tvalid outputs go high the next cycle (latency 1).
  - req_op is pushed into the opcode FIFO.
- tdata stays stable while its tvalid is high. tvalid never drops before its handshake.
- Outstanding counter:
  - +1 on accept; -1 on result handshake.
  - Both events in the same cycle: count unchanged.
  - Never exceeds MAX_OUTSTANDING and never wraps below 0.
- s_axis_result_tready = opcode FIFO non-empty && (!resp_valid || resp_ready). A result arriving while the FIFO is empty is never accepted.
- Result handshake:
  - Pop the opcode and decode the flag from eq, lt, gt, un.
  - EQ = eq; NE = !eq; LT = lt; LE = lt|eq; GT = gt; GE = gt|eq; reserved opcodes = 0.
  - If un = 1, every opcode yields 0 except NE, which yields 1.
  - resp_result and resp_unordered = un are registered; resp_valid goes high the next cycle (latency 1).
  - Responses are returned in request order.
- Response handshake: resp_valid && resp_ready clears resp_valid. If a new result is accepted in the same cycle, resp_valid stays high with the new data.
- Throughput:
  - One request per cycle is not sustained; a new accept needs both channel FSMs back in IDLE.
  - With zero backpressure the peak rate is one request every 2 cycles.

Optional Feature:
- Macro FPCMP_TIMEOUT_EN.
- When defined:
  - A counter increments on every cycle with outstanding != 0 and no result handshake; it clears on a result handshake or at reset.
  - When the counter reaches TIMEOUT_CYCLES, timeout_err is set and stays sticky until areset.
  - Datapath behaviour is unchanged.
- When undefined: timeout_err is tied to 0 and no counter logic is synthesized.

Test Plan:
1. NE, a=32'h3fc00000 (1.5), b=32'h40200000 (2.5); core returns tdata 8'h02 -> tvalid one cycle after accept, resp_result=32'h1, resp_unordered=0.
2. NE then EQ, a=b=32'h3fc00000; core returns 8'h01 each -> responses in order 32'h0, then 32'h1.
3. GT then LE, a=32'h40200000, b=32'h3fc00000; core returns 8'h04 -> responses 32'h1, then 32'h0.
4. EQ then NE, a=32'h7fc00000 (NaN), b=32'h3f800000; core returns 8'h08 -> responses 32'h0, then 32'h1; resp_unordered=1 on both.
5. Backpressure case:
   - Hold m_axis_a_tready low 5 cycles with B ready -> A tvalid and tdata held stable, req_ready low until A completes.
   - Issue 4 requests with no results (MAX_OUTSTANDING=4) -> 5th request stalls.
   - Hold resp_ready low -> s_axis_result_tready low once resp_valid is high.
6. With FPCMP_TIMEOUT_EN and TIMEOUT_CYCLES=64: one request, no result -> timeout_err rises after 64 cycles, stays high, clears only on areset. Without the macro, timeout_err stays 0.
